// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with per-entry saturating counters and branch/mispredict statistics
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            predict_taken_o,
  output logic [XLEN-1:0] predict_target_o,
  input  logic            update_valid_i,
  input  logic [XLEN-1:0] update_pc_i,
  input  logic            update_taken_i,
  input  logic [XLEN-1:0] update_target_i,
  input  logic            update_pred_taken_i,
  input  logic [XLEN-1:0] update_pred_target_i,
  input  logic            clear_i,
  output logic            mispredict_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispredict_cnt_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];
  logic [31:0]      branch_cnt_q, mispredict_cnt_q;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, u_write;
  logic [CTR_W-1:0] u_ctr, u_ctr_d;
  logic             unused_pc_lsbs;

  assign l_idx = pc_i[IDX_W+1:2];
  assign l_tag = pc_i[XLEN-1:IDX_W+2];
  assign u_idx = update_pc_i[IDX_W+1:2];
  assign u_tag = update_pc_i[XLEN-1:IDX_W+2];
  assign unused_pc_lsbs = ^{pc_i[1:0], update_pc_i[1:0]};

  // Lookup reads the table as it stands before this cycle's edge (no bypass).
  always_comb begin
    l_hit            = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    predict_taken_o  = l_hit && ctr_q[l_idx][CTR_W-1];
    predict_target_o = predict_taken_o ? target_q[l_idx] : pc_i + XLEN'(4);
  end

  // Next counter value for the resolved branch; a taken miss allocates weakly taken.
  always_comb begin
    u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_ctr   = ctr_q[u_idx];
    u_write = update_valid_i && (u_hit || update_taken_i);
    u_ctr_d = !u_hit ? CTR_WT :
              update_taken_i ? ((u_ctr == CTR_MAX) ? u_ctr : u_ctr + CTR_W'(1)) :
              ((u_ctr == '0) ? u_ctr : u_ctr - CTR_W'(1));
    mispredict_o = update_valid_i &&
                   ((update_pred_taken_i != update_taken_i) ||
                    (update_taken_i && update_pred_taken_i && (update_pred_target_i != update_target_i)));
  end

  // Table state: clear overrides a same-cycle update; a not-taken miss leaves the slot alone.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (u_write) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= update_taken_i ? update_target_i : target_q[u_idx];
      ctr_q[u_idx]    <= u_ctr_d;
    end
  end

  // Saturating statistics; counted even when clear drops the table update.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (update_valid_i && !(&branch_cnt_q)) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict_o && !(&mispredict_cnt_q)) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors with hand-computed expectations for branch_predictor
module tb_branch_predictor;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] pc_i = 32'h40;
  logic        predict_taken_o;
  logic [31:0] predict_target_o;
  logic        update_valid_i = 1'b0;
  logic [31:0] update_pc_i = '0;
  logic        update_taken_i = 1'b0;
  logic [31:0] update_target_i = '0;
  logic        update_pred_taken_i = 1'b0;
  logic [31:0] update_pred_target_i = '0;
  logic        clear_i = 1'b0;
  logic        mispredict_o;
  logic [31:0] branch_cnt_o, mispredict_cnt_o;
  int checks = 0;
  int failures = 0;

  branch_predictor dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i),
    .predict_taken_o(predict_taken_o), .predict_target_o(predict_target_o),
    .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
    .update_taken_i(update_taken_i), .update_target_i(update_target_i),
    .update_pred_taken_i(update_pred_taken_i), .update_pred_target_i(update_pred_target_i),
    .clear_i(clear_i), .mispredict_o(mispredict_o),
    .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_tgt);
    pc_i = pc;
    #1;
    chk({tag, ".taken"}, predict_taken_o, exp_t);
    chk({tag, ".target"}, predict_target_o, exp_tgt);
  endtask

  task automatic counts(input string tag, input logic [31:0] b, input logic [31:0] m);
    chk({tag, ".branch_cnt"}, branch_cnt_o, b);
    chk({tag, ".mis_cnt"}, mispredict_cnt_o, m);
  endtask

  task automatic upd(input string tag, input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic pt, input logic [31:0] ptgt, input logic exp_mis);
    update_valid_i = 1'b1;
    update_pc_i = pc;
    update_taken_i = t;
    update_target_i = tgt;
    update_pred_taken_i = pt;
    update_pred_target_i = ptgt;
    #1;
    chk({tag, ".mispredict"}, mispredict_o, exp_mis);
    @(posedge clk_i);
    #1;
    update_valid_i = 1'b0;
    clear_i = 1'b0;
  endtask

  initial begin
    #1;
    look("reset", 32'h40, 1'b0, 32'h44);
    counts("reset", 0, 0);
    #11 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("idle.mispredict", mispredict_o, 1'b0);
    upd("alloc", 32'h40, 1, 32'h20, 0, 0, 1);
    look("alloc", 32'h40, 1'b1, 32'h20);
    counts("alloc", 1, 1);
    upd("nt1", 32'h40, 0, 0, 1, 32'h20, 1);
    look("nt1", 32'h40, 1'b0, 32'h44);
    upd("nt2", 32'h40, 0, 0, 0, 0, 0);
    upd("nt3", 32'h40, 0, 0, 0, 0, 0);
    look("nt3", 32'h40, 1'b0, 32'h44);
    upd("t1", 32'h40, 1, 32'h20, 0, 0, 1);
    look("t1", 32'h40, 1'b0, 32'h44);
    upd("t2", 32'h40, 1, 32'h20, 0, 0, 1);
    look("t2", 32'h40, 1'b1, 32'h20);
    upd("t3", 32'h40, 1, 32'h20, 1, 32'h20, 0);
    upd("tsat", 32'h40, 1, 32'h20, 1, 32'h24, 1);
    upd("sat_nt1", 32'h40, 0, 0, 1, 32'h20, 1);
    look("sat_nt1", 32'h40, 1'b1, 32'h20);
    upd("sat_nt2", 32'h40, 0, 0, 1, 32'h20, 1);
    look("sat_nt2", 32'h40, 1'b0, 32'h44);
    upd("retarget", 32'h40, 1, 32'h30, 0, 0, 1);
    look("retarget", 32'h40, 1'b1, 32'h30);
    counts("retarget", 11, 8);
    look("alias_miss", 32'h80, 1'b0, 32'h84);
    upd("alias_nt", 32'h80, 0, 0, 0, 0, 0);
    look("alias_nt80", 32'h80, 1'b0, 32'h84);
    look("alias_nt40", 32'h40, 1'b1, 32'h30);
    upd("alias_t", 32'h80, 1, 32'h100, 0, 0, 1);
    look("alias_t80", 32'h80, 1'b1, 32'h100);
    look("alias_t40", 32'h40, 1'b0, 32'h44);
    upd("realloc", 32'h40, 1, 32'h20, 0, 0, 1);
    look("realloc40", 32'h40, 1'b1, 32'h20);
    look("realloc80", 32'h80, 1'b0, 32'h84);
    pc_i = 32'h40;
    update_valid_i = 1'b1;
    update_pc_i = 32'h40;
    update_taken_i = 1'b0;
    update_pred_taken_i = 1'b1;
    update_pred_target_i = 32'h20;
    #1;
    chk("rbw.taken", predict_taken_o, 1'b1);
    chk("rbw.target", predict_target_o, 32'h20);
    chk("rbw.mispredict", mispredict_o, 1'b1);
    @(posedge clk_i);
    #1;
    update_valid_i = 1'b0;
    look("rbw_next", 32'h40, 1'b0, 32'h44);
    upd("rearm", 32'h40, 1, 32'h20, 0, 0, 1);
    upd("idx1", 32'h44, 1, 32'h200, 0, 0, 1);
    look("idx1", 32'h44, 1'b1, 32'h200);
    look("idx0", 32'h40, 1'b1, 32'h20);
    clear_i = 1'b1;
    upd("clear", 32'h40, 1, 32'h20, 1, 32'h20, 0);
    look("clear40", 32'h40, 1'b0, 32'h44);
    look("clear44", 32'h44, 1'b0, 32'h48);
    counts("clear", 18, 13);
    upd("post_clear", 32'h40, 1, 32'h20, 0, 0, 1);
    look("post_clear", 32'h40, 1'b1, 32'h20);
    counts("post_clear", 19, 14);
    update_valid_i = 1'b1;
    update_pc_i = 32'h80;
    update_taken_i = 1'b1;
    update_target_i = 32'h300;
    update_pred_taken_i = 1'b0;
    rst_i = 1'b0;
    #1;
    look("mid_rst", 32'h40, 1'b0, 32'h44);
    counts("mid_rst", 0, 0);
    #2 rst_i = 1'b1;
    update_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    look("rst_rel40", 32'h40, 1'b0, 32'h44);
    look("rst_rel80", 32'h80, 1'b0, 32'h84);
    counts("rst_rel", 0, 0);
    upd("after_rst", 32'h40, 1, 32'h20, 1, 32'h20, 0);
    look("after_rst", 32'h40, 1'b1, 32'h20);
    counts("after_rst", 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipelined CPU. Replaces static predict-not-taken plus ID-stage flush with a direct-mapped branch target buffer (BTB) and per-entry saturating counters. Looked up combinationally by the IF stage with the current PC. Updated by the ID stage when a branch resolves; also keeps branch and mispredict statistics.

## Interface
- XLEN, 32, address/data width.
- ENTRIES, 16, BTB entries; power of two, ≥2; IDX_W = log2(ENTRIES).
- CTR_W, 2, saturating counter width, 1..4.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- pc_i  in  XLEN  IF-stage PC to predict.
- predict_taken_o  out  1  predicted taken.
- predict_target_o  out  XLEN  predicted next PC.
- update_valid_i  in  1  a branch resolved in ID this cycle.
- update_pc_i  in  XLEN  PC of the resolved branch.
- update_taken_i  in  1  actual outcome.
- update_target_i  in  XLEN  actual taken target.
- update_pred_taken_i  in  1  prediction that branch carried down the pipe.
- update_pred_target_i  in  XLEN  predicted target that branch carried.
- clear_i  in  1  synchronous invalidate of all entries.
- mispredict_o  out  1  flush request for the resolved branch (combinational).
- branch_cnt_o  out  32  resolved-branch count.
- mispredict_cnt_o  out  32  mispredict count.

## Operation
- Entry = {valid, tag, target[XLEN-1:0], ctr[CTR_W-1:0]}.
- Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
- Lookup (combinational):
  - hit = valid & tag match.
  - predict_taken_o = hit & ctr[CTR_W-1].
  - predict_target_o = target when predict_taken_o, else pc_i+4 (mod 2^XLEN).
- Update on edge when update_valid_i:
  - Hit, taken: ctr saturating +1; target ← update_target_i.
  - Hit, not taken: ctr saturating −1; target unchanged.
  - Miss, taken: allocate/overwrite slot. valid=1, tag, target, ctr = 2^(CTR_W-1) (weakly taken).
  - Miss, not taken: no change.
- mispredict_o = update_valid_i & ((update_pred_taken_i ≠ update_taken_i) | (update_taken_i & update_pred_taken_i & update_pred_target_i ≠ update_target_i)).
- Statistics:
  - branch_cnt_o +1 per update_valid_i.
  - mispredict_cnt_o +1 per mispredict_o.
  - Both saturate at 0xFFFFFFFF; only rst_i clears them.
- clear_i: all valid ← 0, all ctr ← 2^(CTR_W-1)−1 (weakly not taken).
  - Priority over a same-cycle update; that update is dropped from the table.
  - The dropped update is still counted in the statistics.

## Timing
- Reset (rst_i low, asynchronous):
  - All valid = 0; all ctr = 2^(CTR_W-1)−1; counters = 0.
  - Outputs immediately: predict_taken_o = 0, predict_target_o = pc_i+4, statistics 0.
  - Mid-operation assertion has the same effect, independent of clk_i.
  - Updates in flight at reset are lost.
- Lookup latency 0 cycles (combinational from pc_i and state).
- Update visible to lookups from the cycle after the capturing edge.
- Same-cycle lookup and update to the same index return pre-update state: read-before-write, no bypass.
- mispredict_o is combinational in the update cycle; the CPU uses it as the IF/ID flush and PC redirect.
- Aliasing: a different tag at the same index evicts only on a taken miss.

## Test plan
- Reset, pc_i=0x40 → predict_taken_o=0, predict_target_o=0x44, both counts 0.
- Update pc=0x40 taken target=0x20, pred_taken=0 → mispredict_o=1 that cycle. Next cycle pc_i=0x40 → taken, 0x20; ctr=2; branch_cnt=1, mispredict_cnt=1.
- Saturation (CTR_W=2), starting from ctr=2:
  - Three not-taken updates to 0x40 → ctr 1,0,0; predict not taken after the first.
  - Then three taken updates → ctr 1,2,3; predict taken from ctr=2.
  - A further taken update holds ctr at 3.
- Alias, with 0x40 entry present:
  - pc_i=0x80 → miss, target 0x84.
  - Update 0x80 not taken → no change.
  - Update 0x80 taken target 0x100 → 0x80 predicts 0x100; 0x40 now misses.
- Same-cycle and clear cases:
  - Update 0x40 not taken while pc_i=0x40 at ctr=2 → still predicts taken that cycle, not taken next.
  - clear_i with update 0x40 taken in the same cycle → all lookups miss next cycle; branch_cnt still increments.
- Assert rst_i low mid-cycle with entries valid and counts nonzero → outputs clear before the next edge; on release, 0x40 misses.
